// File: rtl/fb_line_writer.sv
// fb_line_writer: packs an RGB565 pixel stream (two pixels per 32-bit word, even pixel
// in [15:0]) and writes one framebuffer line to DDR3 through MIG write port p0 as
// fixed-length bursts.
// Byte address of a burst is {line, word_idx[8:0], 2'b00}, zero-extended to 30 bits.
// Optional feature macro: FB_LINE_WRITER_FILL_EN adds fill_en/fill_color ports, which
// write a whole line with a constant colour instead of the pixel stream.
`timescale 1ns/1ps

module fb_line_writer #(
  parameter int BURST_LEN  = 16,
  parameter int LINE_WORDS = 512
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_start,
  input  logic [15:0] wr_line_addr,
  output logic        busy,
  output logic        done,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  output logic        c3_p0_cmd_en,
  input  logic        c3_p0_cmd_full,
  output logic        c3_p0_cmd_rw,
  output logic [5:0]  c3_p0_cmd_bl,
  output logic [29:0] c3_p0_cmd_byte_addr,
  output logic        c3_p0_wr_en,
  output logic [31:0] c3_p0_wr_data,
  output logic [3:0]  c3_p0_wr_mask,
  input  logic        c3_p0_wr_full
`ifdef FB_LINE_WRITER_FILL_EN
  ,
  input  logic        fill_en,
  input  logic [15:0] fill_color
`endif
);

  localparam int WIDX_W = $clog2(LINE_WORDS + 1);
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [WIDX_W-1:0] BURST_STEP = WIDX_W'(BURST_LEN);
  localparam logic [WIDX_W-1:0] LINE_END   = WIDX_W'(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_CMD  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         line_q, line_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                half_q, half_d;
  logic [15:0]         low_q, low_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cmd_en_q, cmd_en_d;
  logic [5:0]          cmd_bl_q, cmd_bl_d;
  logic [29:0]         cmd_addr_q, cmd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         wr_data_q, wr_data_d;
`ifdef FB_LINE_WRITER_FILL_EN
  logic                fill_q, fill_d;
  logic [15:0]         fill_color_q, fill_color_d;
`endif

  logic                pix_ready_s;
  logic                push_s;
  logic [31:0]         push_data_s;
  logic [WIDX_W-1:0]   word_next_s;
  logic [8:0]          word_lo_s;

  assign word_next_s = word_idx_q + BURST_STEP;
  assign word_lo_s   = 9'(word_idx_q);

  // Next-state logic: pixel packing, burst counting and MIG command issue.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    word_idx_d  = word_idx_q;
    burst_cnt_d = burst_cnt_q;
    half_d      = half_q;
    low_d       = low_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cmd_en_d    = 1'b0;
    cmd_bl_d    = cmd_bl_q;
    cmd_addr_d  = cmd_addr_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    pix_ready_s = 1'b0;
    push_s      = 1'b0;
    push_data_s = 32'd0;
`ifdef FB_LINE_WRITER_FILL_EN
    fill_d       = fill_q;
    fill_color_d = fill_color_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          line_d      = wr_line_addr;
          word_idx_d  = {WIDX_W{1'b0}};
          burst_cnt_d = {BCNT_W{1'b0}};
          half_d      = 1'b0;
          busy_d      = 1'b1;
`ifdef FB_LINE_WRITER_FILL_EN
          fill_d       = fill_en;
          fill_color_d = fill_color;
`endif
          state_d     = S_FILL;
        end else begin
          state_d     = S_IDLE;
        end
      end

      S_FILL: begin
`ifdef FB_LINE_WRITER_FILL_EN
        if (fill_q) begin
          // Constant-colour line: one word per cycle, pixel stream untouched.
          if (!c3_p0_wr_full) begin
            push_s      = 1'b1;
            push_data_s = {fill_color_q, fill_color_q};
          end else begin
            push_s      = 1'b0;
          end
        end else begin
`endif
          pix_ready_s = !c3_p0_wr_full;
          if (pix_valid && pix_ready_s) begin
            if (half_q) begin
              push_s      = 1'b1;
              push_data_s = {pix_data, low_q};
              half_d      = 1'b0;
            end else begin
              low_d       = pix_data;
              half_d      = 1'b1;
            end
          end else begin
            // Stall keeps any held low half untouched.
            low_d       = low_q;
          end
`ifdef FB_LINE_WRITER_FILL_EN
        end
`endif
        if (push_s) begin
          wr_en_d   = 1'b1;
          wr_data_d = push_data_s;
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = {BCNT_W{1'b0}};
            state_d     = S_CMD;
          end else begin
            burst_cnt_d = burst_cnt_q + BCNT_W'(1);
          end
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end

      S_CMD: begin
        // The command always trails its burst's data, so MIG never sees a short burst.
        if (!c3_p0_cmd_full) begin
          cmd_en_d   = 1'b1;
          cmd_bl_d   = 6'(BURST_LEN - 1);
          cmd_addr_d = {3'b000, line_q, word_lo_s, 2'b00};
          word_idx_d = word_next_s;
          if (word_next_s == LINE_END) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_CMD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      line_q      <= 16'd0;
      word_idx_q  <= {WIDX_W{1'b0}};
      burst_cnt_q <= {BCNT_W{1'b0}};
      half_q      <= 1'b0;
      low_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_en_q    <= 1'b0;
      cmd_bl_q    <= 6'd0;
      cmd_addr_q  <= 30'd0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 32'd0;
`ifdef FB_LINE_WRITER_FILL_EN
      fill_q       <= 1'b0;
      fill_color_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      word_idx_q  <= word_idx_d;
      burst_cnt_q <= burst_cnt_d;
      half_q      <= half_d;
      low_q       <= low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_en_q    <= cmd_en_d;
      cmd_bl_q    <= cmd_bl_d;
      cmd_addr_q  <= cmd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
`ifdef FB_LINE_WRITER_FILL_EN
      fill_q       <= fill_d;
      fill_color_q <= fill_color_d;
`endif
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign pix_ready           = pix_ready_s;
  assign c3_p0_cmd_en        = cmd_en_q;
  assign c3_p0_cmd_rw        = 1'b0;
  assign c3_p0_cmd_bl        = cmd_bl_q;
  assign c3_p0_cmd_byte_addr = cmd_addr_q;
  assign c3_p0_wr_en         = wr_en_q;
  assign c3_p0_wr_data       = wr_data_q;
  assign c3_p0_wr_mask       = 4'b0000;

endmodule

// File: tb/tb_fb_line_writer.sv
// Directed bench for fb_line_writer: full lines with and without backpressure,
// ignored restart, top line address, mid-line reset and (when built with
// FB_LINE_WRITER_FILL_EN) the constant-colour fill path.
`timescale 1ns/1ps

module tb_fb_line_writer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wr_start;
  logic [15:0] wr_line_addr;
  logic        busy, done;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        c3_p0_cmd_en;
  logic        c3_p0_cmd_full;
  logic        c3_p0_cmd_rw;
  logic [5:0]  c3_p0_cmd_bl;
  logic [29:0] c3_p0_cmd_byte_addr;
  logic        c3_p0_wr_en;
  logic [31:0] c3_p0_wr_data;
  logic [3:0]  c3_p0_wr_mask;
  logic        c3_p0_wr_full;
`ifdef FB_LINE_WRITER_FILL_EN
  logic        fill_en;
  logic [15:0] fill_color;
`endif

  int total = 0;
  int bad   = 0;

  // Monitor state (written only by the monitor process)
  logic [31:0] wq[$];
  logic [29:0] cq[$];
  logic [5:0]  blq[$];
  int done_cnt   = 0;
  int viol_wr    = 0;
  int viol_cmd   = 0;
  int viol_order = 0;
  int viol_busy  = 0;
  int viol_ready = 0;
  int wsince     = 0;
  logic prev_wr_full  = 1'b0;
  logic prev_cmd_full = 1'b0;
  logic prev_busy     = 1'b0;

  fb_line_writer dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .wr_start           (wr_start),
    .wr_line_addr       (wr_line_addr),
    .busy               (busy),
    .done               (done),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .pix_data           (pix_data),
    .c3_p0_cmd_en       (c3_p0_cmd_en),
    .c3_p0_cmd_full     (c3_p0_cmd_full),
    .c3_p0_cmd_rw       (c3_p0_cmd_rw),
    .c3_p0_cmd_bl       (c3_p0_cmd_bl),
    .c3_p0_cmd_byte_addr(c3_p0_cmd_byte_addr),
    .c3_p0_wr_en        (c3_p0_wr_en),
    .c3_p0_wr_data      (c3_p0_wr_data),
    .c3_p0_wr_mask      (c3_p0_wr_mask),
    .c3_p0_wr_full      (c3_p0_wr_full)
`ifdef FB_LINE_WRITER_FILL_EN
    ,
    .fill_en            (fill_en),
    .fill_color         (fill_color)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: record strobes mid-cycle and flag protocol violations.
  always @(negedge sys_clk) begin
    if (c3_p0_wr_en) begin
      wq.push_back(c3_p0_wr_data);
      wsince++;
      if (prev_wr_full) viol_wr++;
    end
    if (c3_p0_cmd_en) begin
      if (prev_cmd_full) viol_cmd++;
      if (wsince < 16) viol_order++;
      wsince = 0;
      cq.push_back(c3_p0_cmd_byte_addr);
      blq.push_back(c3_p0_cmd_bl);
    end
    if (done) done_cnt++;
    if (prev_busy && !busy && !done) viol_busy++;
`ifdef FB_LINE_WRITER_FILL_EN
    if (pix_ready && fill_en) viol_ready++;
`endif
    prev_wr_full  = c3_p0_wr_full;
    prev_cmd_full = c3_p0_cmd_full;
    prev_busy     = busy;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one line and stream pixels 0..1023 until done (or until rst_after pixels).
  task automatic run_line(input logic [15:0] line, input bit bp, input bit restart,
                          input int rst_after, output int npix);
    int  cyc;
    int  db;
    bit  acc;
    bit  restarted;
    restarted = 1'b0;
    db        = done_cnt;
    wr_start     = 1'b1;
    wr_line_addr = line;
    @(posedge sys_clk); #1;
    wr_start     = 1'b0;
    wr_line_addr = 16'hAAAA;
    npix = 0;
    cyc  = 0;
    while (done_cnt == db && cyc < 6000 && !(rst_after > 0 && npix >= rst_after)) begin
      pix_valid = (npix < 1024);
      pix_data  = 16'(npix);
      if (bp) begin
        c3_p0_wr_full  = ($urandom_range(0, 3) == 0);
        c3_p0_cmd_full = ($urandom_range(0, 2) == 0);
      end else begin
        c3_p0_wr_full  = 1'b0;
        c3_p0_cmd_full = 1'b0;
      end
      if (restart && !restarted && npix == 500) begin
        wr_start     = 1'b1;
        wr_line_addr = 16'h0033;
        restarted    = 1'b1;
      end else begin
        wr_start     = 1'b0;
      end
      #1;
      acc = pix_valid && pix_ready;
      @(posedge sys_clk); #1;
      if (acc) npix++;
      cyc++;
    end
    pix_valid      = 1'b0;
    wr_start       = 1'b0;
    c3_p0_wr_full  = 1'b0;
    c3_p0_cmd_full = 1'b0;
    if (rst_after == 0) chk("line_timeout", 64'(cyc < 6000), 64'd1);
  endtask

  // Compare words and commands captured since snapshot (wb, cb) against the model.
  task automatic check_line(input string tag, input logic [15:0] line, input int wb,
                            input int cb, input bit fill, input logic [15:0] color);
    logic [31:0] ew;
    logic [29:0] ea;
    chk({tag, "_nwords"}, 64'(wq.size() - wb), 64'd512);
    chk({tag, "_ncmds"},  64'(cq.size() - cb), 64'd32);
    for (int k = 0; k < 512 && (wb + k) < wq.size(); k++) begin
      ew = fill ? {color, color} : {16'(2 * k + 1), 16'(2 * k)};
      chk({tag, "_word"}, 64'(wq[wb + k]), 64'(ew));
    end
    for (int k = 0; k < 32 && (cb + k) < cq.size(); k++) begin
      ea = 30'(line) * 30'd2048 + 30'(k) * 30'd64;
      chk({tag, "_addr"}, 64'(cq[cb + k]), 64'(ea));
      chk({tag, "_bl"},   64'(blq[cb + k]), 64'd15);
    end
  endtask

  initial begin
    int np;
    int wb, cb, db, vw, vc, vo, vb;
    sys_rst_n      = 1'b0;
    wr_start       = 1'b0;
    wr_line_addr   = 16'd0;
    pix_valid      = 1'b0;
    pix_data       = 16'd0;
    c3_p0_cmd_full = 1'b0;
    c3_p0_wr_full  = 1'b0;
`ifdef FB_LINE_WRITER_FILL_EN
    fill_en    = 1'b0;
    fill_color = 16'd0;
`endif
    repeat (3) @(posedge sys_clk);
    #1;
    // Reset state
    chk("reset_outs", 64'({busy, done, pix_ready, c3_p0_cmd_en, c3_p0_cmd_rw, c3_p0_cmd_bl,
                           c3_p0_cmd_byte_addr, c3_p0_wr_en, c3_p0_wr_mask}), 64'd0);
    chk("reset_wdata", 64'(c3_p0_wr_data), 64'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // 1: line 5, continuous pixels
    wb = wq.size(); cb = cq.size(); db = done_cnt; vo = viol_order;
    run_line(16'd5, 1'b0, 1'b0, 0, np);
    repeat (3) @(posedge sys_clk); #1;
    check_line("t1", 16'd5, wb, cb, 1'b0, 16'd0);
    chk("t1_done_pulses", 64'(done_cnt - db), 64'd1);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_cmd_order", 64'(viol_order - vo), 64'd0);

    // 2: random wr_full / cmd_full backpressure
    wb = wq.size(); cb = cq.size(); db = done_cnt;
    vw = viol_wr; vc = viol_cmd; vo = viol_order;
    run_line(16'd5, 1'b1, 1'b0, 0, np);
    repeat (3) @(posedge sys_clk); #1;
    check_line("t2", 16'd5, wb, cb, 1'b0, 16'd0);
    chk("t2_done_pulses", 64'(done_cnt - db), 64'd1);
    chk("t2_wr_en_while_full", 64'(viol_wr - vw), 64'd0);
    chk("t2_cmd_en_while_full", 64'(viol_cmd - vc), 64'd0);
    chk("t2_cmd_order", 64'(viol_order - vo), 64'd0);

    // 3: second wr_start mid-line is ignored
    wb = wq.size(); cb = cq.size(); db = done_cnt; vb = viol_busy;
    run_line(16'd7, 1'b0, 1'b1, 0, np);
    repeat (3) @(posedge sys_clk); #1;
    check_line("t3", 16'd7, wb, cb, 1'b0, 16'd0);
    chk("t3_done_pulses", 64'(done_cnt - db), 64'd1);
    chk("t3_busy_drop_without_done", 64'(viol_busy - vb), 64'd0);

    // 4: highest line index
    wb = wq.size(); cb = cq.size();
    run_line(16'hFFFF, 1'b0, 1'b0, 0, np);
    repeat (3) @(posedge sys_clk); #1;
    check_line("t4", 16'hFFFF, wb, cb, 1'b0, 16'd0);
    chk("t4_last_addr", 64'(cq[cq.size() - 1]), 64'h7FFFFC0);
    chk("t4_addr_top_bits", 64'(cq[cq.size() - 1] >> 27), 64'd0);

    // 5: reset after 300 pixels, then a clean line 2
    run_line(16'd9, 1'b0, 1'b0, 300, np);
    chk("t5_pixels_before_reset", 64'(np), 64'd300);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("t5_reset_outs", 64'({busy, done, pix_ready, c3_p0_cmd_en, c3_p0_cmd_rw, c3_p0_cmd_bl,
                              c3_p0_cmd_byte_addr, c3_p0_wr_en, c3_p0_wr_mask}), 64'd0);
    chk("t5_reset_wdata", 64'(c3_p0_wr_data), 64'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    wb = wq.size(); cb = cq.size(); db = done_cnt;
    run_line(16'd2, 1'b0, 1'b0, 0, np);
    repeat (3) @(posedge sys_clk); #1;
    check_line("t5", 16'd2, wb, cb, 1'b0, 16'd0);
    chk("t5_first_addr", 64'(cq[cb]), 64'h1000);
    chk("t5_done_pulses", 64'(done_cnt - db), 64'd1);

`ifdef FB_LINE_WRITER_FILL_EN
    // 6: constant-colour fill, pixel stream ignored
    fill_en    = 1'b1;
    fill_color = 16'hF800;
    wb = wq.size(); cb = cq.size(); db = done_cnt; vb = viol_ready;
    run_line(16'd3, 1'b0, 1'b0, 0, np);
    repeat (3) @(posedge sys_clk); #1;
    check_line("t6", 16'd3, wb, cb, 1'b1, 16'hF800);
    chk("t6_pix_ready_seen", 64'(viol_ready - vb), 64'd0);
    chk("t6_pixels_taken", 64'(np), 64'd0);
    chk("t6_done_pulses", 64'(done_cnt - db), 64'd1);
    fill_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
